// File: rtl/denormalize64_pipe.sv
// 3-stage pipelined 64-bit right shifter with sticky (OR of shifted-out bits).
// Define DENORM64_JAM_EN to jam the sticky bit into out_sig[0].
module denormalize64_pipe #(
  parameter int unsigned TAG_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_sig,
  input  logic [5:0]       in_dist,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_sig,
  output logic             out_sticky,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [63:0] ONES = '1;

  logic             adv;

  logic             s1_valid, s2_valid, s3_valid;
  logic [63:0]      s1_sig, s2_sig, s3_sig;
  logic             s1_sticky, s2_sticky, s3_sticky;
  logic [3:0]       s1_dist;
  logic [1:0]       s2_dist;
  logic [TAG_W-1:0] s1_tag, s2_tag, s3_tag;

  logic [5:0]       sh1, sh2, sh3;
  logic [63:0]      s1_sig_d, s2_sig_d, s3_sig_d;
  logic             s1_sticky_d, s2_sticky_d, s3_sticky_d;

  // Single enable: the whole pipe moves together, so bubbles are never squeezed out.
  assign adv      = ~s3_valid | out_ready;
  assign in_ready = adv;

  always_comb begin
    sh1 = {in_dist[5:4], 4'b0000};
    sh2 = {2'b00, s1_dist[3:2], 2'b00};
    sh3 = {4'b0000, s2_dist};

    s1_sig_d    = in_sig >> sh1;
    s1_sticky_d = |(in_sig & ~(ONES << sh1));

    s2_sig_d    = s1_sig >> sh2;
    s2_sticky_d = s1_sticky | (|(s1_sig & ~(ONES << sh2)));

    s3_sig_d    = s2_sig >> sh3;
    s3_sticky_d = s2_sticky | (|(s2_sig & ~(ONES << sh3)));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s3_valid  <= 1'b0;
      s1_sig    <= '0;
      s2_sig    <= '0;
      s3_sig    <= '0;
      s1_sticky <= 1'b0;
      s2_sticky <= 1'b0;
      s3_sticky <= 1'b0;
      s1_dist   <= '0;
      s2_dist   <= '0;
      s1_tag    <= '0;
      s2_tag    <= '0;
      s3_tag    <= '0;
    end else if (adv) begin
      s1_valid  <= in_valid;
      s1_sig    <= s1_sig_d;
      s1_sticky <= s1_sticky_d;
      s1_dist   <= in_dist[3:0];
      s1_tag    <= in_tag;

      s2_valid  <= s1_valid;
      s2_sig    <= s2_sig_d;
      s2_sticky <= s2_sticky_d;
      s2_dist   <= s1_dist[1:0];
      s2_tag    <= s1_tag;

      s3_valid  <= s2_valid;
      s3_sig    <= s3_sig_d;
      s3_sticky <= s3_sticky_d;
      s3_tag    <= s2_tag;
    end
  end

  assign out_valid  = s3_valid;
  assign out_sticky = s3_sticky;
  assign out_tag    = s3_tag;

`ifdef DENORM64_JAM_EN
  assign out_sig = {s3_sig[63:1], s3_sig[0] | s3_sticky};
`else
  assign out_sig = s3_sig;
`endif

endmodule

// File: tb/tb_denormalize64_pipe.sv
// Directed self-checking bench for denormalize64_pipe (reset, vectors, back-pressure, mid-flight reset).
module tb_denormalize64_pipe;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_sig;
  logic [5:0]  in_dist;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_sig;
  logic        out_sticky;
  logic [3:0]  out_tag;

  int unsigned compared;
  int unsigned failed;

  denormalize64_pipe #(.TAG_W(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sig     (in_sig),
    .in_dist    (in_dist),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sig    (out_sig),
    .out_sticky (out_sticky),
    .out_tag    (out_tag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive point: just after the active edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Sample point: the falling edge.
  task automatic sample();
    @(negedge clock);
  endtask

  function automatic logic [63:0] jam(input logic [63:0] s, input logic st);
`ifdef DENORM64_JAM_EN
    return s | {63'b0, st};
`else
    return s;
`endif
  endfunction

  task automatic run_vec(input string name, input logic [63:0] s, input logic [5:0] d,
                         input logic [3:0] t, input logic [63:0] exp_sig, input logic exp_st);
    in_valid = 1'b1;
    in_sig   = s;
    in_dist  = d;
    in_tag   = t;
    step();
    in_valid = 1'b0;
    in_sig   = '0;
    in_dist  = '0;
    in_tag   = '0;
    step();
    sample();
    check({name, "_early"}, {63'b0, out_valid}, 64'd0);
    step();
    sample();
    check({name, "_valid"}, {63'b0, out_valid}, 64'd1);
    check({name, "_sig"}, out_sig, jam(exp_sig, exp_st));
    check({name, "_sticky"}, {63'b0, out_sticky}, {63'b0, exp_st});
    check({name, "_tag"}, {60'b0, out_tag}, {60'b0, t});
    step();
  endtask

  initial begin
    int unsigned sent;
    int unsigned recv;
    int unsigned stall_cycles;
    bit          first_seen;
    bit          prev_stalled;
    logic [63:0] prev_sig;
    logic [3:0]  prev_tag;

    compared  = 0;
    failed    = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_sig    = '0;
    in_dist   = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    step();
    step();
    reset = 1'b0;
    sample();
    check("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_out_sig", out_sig, 64'd0);
    check("rst_out_sticky", {63'b0, out_sticky}, 64'd0);
    check("rst_out_tag", {60'b0, out_tag}, 64'd0);
    check("rst_in_ready", {63'b0, in_ready}, 64'd1);
    step();

    run_vec("v_msb_lsb_d1", 64'h8000_0000_0000_0001, 6'd1, 4'h3, 64'h4000_0000_0000_0000, 1'b1);
    run_vec("v_ones_d63", 64'hFFFF_FFFF_FFFF_FFFF, 6'd63, 4'h5, 64'h1, 1'b1);
    run_vec("v_d0", 64'h1234_5678_9ABC_DEF0, 6'd0, 4'h7, 64'h1234_5678_9ABC_DEF0, 1'b0);
    run_vec("v_d16", 64'h0000_0000_0001_0000, 6'd16, 4'h9, 64'h1, 1'b0);
    run_vec("v_d17", 64'h0000_0000_0001_0000, 6'd17, 4'hA, 64'h0, 1'b1);
    run_vec("v_zero_d37", 64'h0, 6'd37, 4'hB, 64'h0, 1'b0);
    run_vec("v_f0_d4", 64'hF0, 6'd4, 4'hC, 64'hF, 1'b0);
    run_vec("v_f0_d5", 64'hF0, 6'd5, 4'hD, 64'h7, 1'b1);
    run_vec("v_a5_d44", 64'hA5A5_A5A5_A5A5_A5A5, 6'd44, 4'hE, 64'hA_5A5A, 1'b1);
    run_vec("v_top_d63", 64'h7FFF_FFFF_FFFF_FFFF, 6'd63, 4'hF, 64'h0, 1'b1);

    // Back-pressure stream: op i = ((i+1)<<8)|i, dist 8 -> sig i+1, sticky (i!=0).
    sent = 0;
    recv = 0;
    stall_cycles = 0;
    first_seen = 1'b0;
    prev_stalled = 1'b0;
    prev_sig = '0;
    prev_tag = '0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (first_seen && stall_cycles < 4) begin
        out_ready = 1'b0;
        stall_cycles++;
      end else begin
        out_ready = 1'b1;
      end
      if (sent < 5) begin
        in_valid = 1'b1;
        in_sig   = ((64'(sent) + 64'd1) << 8) | 64'(sent);
        in_dist  = 6'd8;
        in_tag   = 4'(sent);
      end else begin
        in_valid = 1'b0;
        in_sig   = '0;
        in_dist  = '0;
        in_tag   = '0;
      end
      sample();
      if (prev_stalled) begin
        check("bp_hold_valid", {63'b0, out_valid}, 64'd1);
        check("bp_hold_sig", out_sig, prev_sig);
        check("bp_hold_tag", {60'b0, out_tag}, {60'b0, prev_tag});
      end
      if (out_valid && !out_ready)
        check("bp_in_ready_low", {63'b0, in_ready}, 64'd0);
      if (out_valid && out_ready) begin
        check("bp_accept_drain", {63'b0, in_ready}, 64'd1);
        check("bp_no_extra", {63'b0, recv < 5}, 64'd1);
        check("bp_tag", {60'b0, out_tag}, 64'(recv));
        check("bp_sig", out_sig, jam(64'(recv) + 64'd1, recv != 0));
        check("bp_sticky", {63'b0, out_sticky}, {63'b0, recv != 0});
        recv++;
        first_seen = 1'b1;
      end
      if (in_valid && in_ready)
        sent++;
      prev_stalled = out_valid && !out_ready;
      prev_sig = out_sig;
      prev_tag = out_tag;
      step();
    end
    check("bp_recv_count", 64'(recv), 64'd5);
    in_valid  = 1'b0;
    out_ready = 1'b1;

    // Reset with three operations in flight.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_sig   = 64'hDEAD_BEEF_0000_0000 | 64'(i);
      in_dist  = 6'd4;
      in_tag   = 4'(i + 8);
      step();
    end
    in_valid = 1'b0;
    sample();
    check("mr_full_valid", {63'b0, out_valid}, 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    sample();
    check("mr_out_valid", {63'b0, out_valid}, 64'd0);
    check("mr_in_ready", {63'b0, in_ready}, 64'd1);
    check("mr_out_sig", out_sig, 64'd0);
    check("mr_out_tag", {60'b0, out_tag}, 64'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      sample();
      check("mr_no_stale", {63'b0, out_valid}, 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
